// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl
// ----------------
// Capture sequencer for an I2S MEMS microphone. On start it generates the
// bit clock (mclk) and word select (ws), throws away WARMUP_FRAMES complete
// frames, deserializes SAMPLE_BITS-wide words from the selected half-frame
// and writes NUM_SAMPLES of them to the sample RAM. Frame = 64 mclk periods,
// ws = slot[5], slot[4:0]==0 is the I2S delay bit, data MSB first in slots
// 1..SAMPLE_BITS.
//
// Ports
//   clk       in   system clock (only clock)
//   reset     in   synchronous, active-low reset
//   start     in   begin capture (sampled only in IDLE; wins over abort)
//   abort     in   cancel capture in WARMUP/CAPTURE, no Done
//   channel   in   0 = left (ws low), 1 = right (ws high), latched on start
//   Dataint   in   serial microphone data
//   mclk      out  microphone bit clock, half-period CLK_DIV clk cycles
//   ws        out  word select
//   mem_we    out  sample RAM write strobe
//   mem_addr  out  write address (held until the next start)
//   mem_data  out  sample, two's complement
//   busy      out  high in WARMUP/CAPTURE
//   Done      out  one-cycle pulse after the last write
//   state_o   out  current FSM state (debug)
//
// Handshake: the RAM write port has no backpressure. mem_we is a one-cycle
// strobe; mem_addr/mem_data are valid in exactly the cycle mem_we is high.
module mic_capture_ctrl #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_BITS   = 18,
    parameter int ADDR_W        = 10,
    parameter int NUM_SAMPLES   = 1024,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   channel,
    input  logic                   Dataint,
    output logic                   mclk,
    output logic                   ws,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [SAMPLE_BITS-1:0] mem_data,
    output logic                   busy,
    output logic                   Done,
    output logic [1:0]             state_o
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WARM_W = 16;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_FRAMES - 1);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
    localparam logic [4:0]        SLOT_LAST = 5'(SAMPLE_BITS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WARMUP  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   mclk_q, mclk_d;
    logic [5:0]             slot_q, slot_d;
    logic [WARM_W-1:0]      warm_q, warm_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic                   last_q, last_d;
    logic                   chan_q, chan_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [SAMPLE_BITS-1:0] data_q, data_d;

    logic                   running;
    logic                   tick;
    logic                   rise;
    logic                   fall;
    logic                   data_slot;
    logic [SAMPLE_BITS-1:0] word_next;

    assign running   = (state_q == S_WARMUP) || (state_q == S_CAPTURE);
    assign tick      = (div_q == DIV_LAST);
    // rise/fall mark the clk cycle at whose end mclk toggles
    assign rise      = running && tick && !mclk_q;
    assign fall      = running && tick && mclk_q;
    assign data_slot = (slot_q[4:0] != 5'd0) && (slot_q[4:0] <= SLOT_LAST);
    // word as it will stand once the current Dataint bit is shifted in
    assign word_next = {shift_q[SAMPLE_BITS-2:0], Dataint};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        mclk_d  = mclk_q;
        slot_d  = slot_q;
        warm_d  = warm_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        last_d  = last_q;
        chan_d  = chan_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                div_d   = '0;
                mclk_d  = 1'b0;
                slot_d  = '0;
                warm_d  = '0;
                shift_d = '0;
                idx_d   = '0;
                if (start) begin
                    chan_d  = channel;
                    addr_d  = '0;
                    state_d = (WARMUP_FRAMES == 0) ? S_CAPTURE : S_WARMUP;
                end
            end

            S_WARMUP, S_CAPTURE: begin
                div_d = tick ? '0 : div_q + DIV_ONE;
                if (tick) begin
                    mclk_d = ~mclk_q;
                end
                if (fall) begin
                    slot_d = slot_q + 6'd1;
                end
                if (rise && data_slot) begin
                    shift_d = word_next;
                end

                if (state_q == S_WARMUP) begin
                    // slot counter keeps running across the switch to CAPTURE
                    if (fall && slot_q == 6'd63) begin
                        if (warm_q == WARM_LAST) begin
                            state_d = S_CAPTURE;
                        end else begin
                            warm_d = warm_q + WARM_ONE;
                        end
                    end
                end else begin
                    if (rise && slot_q[4:0] == SLOT_LAST && slot_q[5] == chan_q) begin
                        we_d   = 1'b1;
                        data_d = word_next;
                        addr_d = idx_q;
                        idx_d  = idx_q + IDX_ONE;
                        last_d = (idx_q == IDX_LAST);
                    end
                    if (we_q && last_q) begin
                        state_d = S_DONE;
                    end
                end

                // abort drops everything in flight, including a word
                // completing in this very cycle
                if (abort) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    mclk_d  = 1'b0;
                    slot_d  = '0;
                    shift_d = '0;
                    we_d    = 1'b0;
                    addr_d  = addr_q;
                    data_d  = data_q;
                    idx_d   = idx_q;
                end
            end

            S_DONE: begin
                div_d   = '0;
                mclk_d  = 1'b0;
                slot_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            mclk_q  <= 1'b0;
            slot_q  <= '0;
            warm_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            chan_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mclk_q  <= mclk_d;
            slot_q  <= slot_d;
            warm_q  <= warm_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // mclk/ws are gated so they read 0 in IDLE and DONE regardless of
    // where the divider stood when the capture ended
    assign mclk     = mclk_q && running;
    assign ws       = slot_q[5] && running;
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign busy     = running;
    assign Done     = (state_q == S_DONE);
    assign state_o  = state_q;

endmodule
